// File: rtl/mul_div_unit_pkg.sv
// Shared types and helpers for the multiply/divide unit: op codes, FSM states,
// divider result payload.
package mul_div_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
  } div_res_t;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on operand magnitudes: one quotient bit per cycle,
// done_o is high during the cycle in which the final step is taken.
module mdu_divider
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            is_signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output div_res_t        res_o
);

  logic [XLEN-1:0]      quot_q, rem_q, dvsr_q;
  logic [XLEN-1:0]      quot_d, rem_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 run_q, done_q;
  logic [XLEN:0]        shifted;
  logic [XLEN+1:0]      diff;
  logic                 fits;

  // One shift/subtract step; partial remainder never exceeds the divisor.
  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, dvsr_q};
    fits    = ~diff[XLEN+1];
    rem_d   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_d  = {quot_q[XLEN-2:0], fits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      quot_q <= neg_if(dividend_i, is_signed_i & dividend_i[XLEN-1]);
      dvsr_q <= neg_if(divisor_i, is_signed_i & divisor_i[XLEN-1]);
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q + DIV_CNT_W'(1);
      done_q <= (cnt_q == DIV_CNT_W'(DIV_STEPS - 2));
      if (cnt_q == DIV_CNT_W'(DIV_STEPS - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o     = done_q;
  assign res_o.quot = quot_q;
  assign res_o.rem  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: op sequencing FSM, registered 64-bit
// product, sign fix-up of divider results, and the HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      ctrl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  mdu_state_e        state_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              q_neg_q, r_neg_q, b_zero_q;
  logic              accept, div_start, div_signed, div_done;
  logic [XLEN-1:0]   fix_lo, fix_hi;
  div_res_t          div_res;

  assign accept     = start && (state_q == ST_IDLE);
  assign div_signed = (ctrl == MDU_DIV);
  assign div_start  = accept && ((ctrl == MDU_DIV) || (ctrl == MDU_DIVU));

  always_comb begin
    prod_d = '0;
    if (ctrl == MDU_MULT) begin
      prod_d = $signed({{XLEN{srcA[XLEN-1]}}, srcA}) * $signed({{XLEN{srcB[XLEN-1]}}, srcB});
    end else begin
      prod_d = {{XLEN{1'b0}}, srcA} * {{XLEN{1'b0}}, srcB};
    end
  end

  // Divide-by-zero forces an all-ones quotient regardless of operand signs.
  always_comb begin
    fix_lo = b_zero_q ? '1 : neg_if(div_res.quot, q_neg_q);
    fix_hi = neg_if(div_res.rem, r_neg_q);
  end

  mdu_divider u_divider (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start),
    .is_signed_i (div_signed),
    .dividend_i  (srcA),
    .divisor_i   (srcB),
    .done_o      (div_done),
    .res_o       (div_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (ctrl)
              MDU_MULT, MDU_MULTU: begin
                prod_q  <= prod_d;
                cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                state_q <= ST_MUL;
                busy_q  <= 1'b1;
              end
              MDU_DIV, MDU_DIVU: begin
                q_neg_q  <= div_signed & (srcA[XLEN-1] ^ srcB[XLEN-1]);
                r_neg_q  <= div_signed & srcA[XLEN-1];
                b_zero_q <= (srcB == '0);
                state_q  <= ST_DIV;
                busy_q   <= 1'b1;
              end
              MDU_MTHI: hi_q <= srcA;
              MDU_MTLO: lo_q <= srcA;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            hi_q    <= prod_q[2*XLEN-1:XLEN];
            lo_q    <= prod_q[XLEN-1:0];
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic HI/LO model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned MUL_CYC = 5;
  localparam int unsigned DIV_CYC = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ctrl  (ctrl),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected HI/LO and busy length from the architectural definition of each op.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] nh, output logic [31:0] nl, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] p;
    nh = exp_hi;
    nl = exp_lo;
    cyc = 0;
    case (op)
      MDU_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        nh = p[63:32]; nl = p[31:0]; cyc = MUL_CYC;
      end
      MDU_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        nh = p[63:32]; nl = p[31:0]; cyc = MUL_CYC;
      end
      MDU_DIV: begin
        cyc = DIV_CYC;
        if (b == 32'd0) begin
          nl = 32'hFFFFFFFF; nh = a;
        end else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          nl = 32'(q); nh = 32'(r);
        end
      end
      MDU_DIVU: begin
        cyc = DIV_CYC;
        if (b == 32'd0) begin
          nl = 32'hFFFFFFFF; nh = a;
        end else begin
          nl = a / b; nh = a % b;
        end
      end
      MDU_MTHI: nh = a;
      MDU_MTLO: nl = a;
      default: ;
    endcase
  endtask

  // Issue one op; while busy, scramble operands and try an mthi that must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int cyc, n;
    ref_model(op, a, b, nh, nl, cyc);
    start = 1'b1; ctrl = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      check("hold_hi", hi, exp_hi);
      check("hold_lo", lo, exp_lo);
      start = (n == 1); ctrl = MDU_MTHI; srcA = $urandom; srcB = $urandom;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("busy_cycles", 32'(n), 32'(cyc));
    check("busy_end", {31'b0, busy}, 32'd0);
    check("hi", hi, nh);
    check("lo", lo, nl);
    exp_hi = nh;
    exp_lo = nl;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; start = 1'b0; ctrl = '0; srcA = '0; srcB = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(MDU_MULT,  32'hFFFFFFFE, 32'd3);
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MDU_DIV,   32'hFFFFFFF9, 32'd2);
    run_op(MDU_DIVU,  32'd7, 32'd2);
    run_op(MDU_DIV,   32'h12345678, 32'd0);
    run_op(MDU_DIV,   32'h80000000, 32'hFFFFFFFF);
    run_op(MDU_DIVU,  32'h80000000, 32'd0);
    run_op(MDU_MTHI,  32'h0BADF00D, 32'd0);
    run_op(MDU_MTLO,  32'hA5A5A5A5, 32'd0);

    // Undefined op codes must not disturb anything.
    start = 1'b1; ctrl = 3'd7; srcA = 32'hDEADBEEF; srcB = 32'd1;
    @(posedge clk); #1;
    ctrl = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("unk_busy", {31'b0, busy}, 32'd0);
    check("unk_hi", hi, exp_hi);
    check("unk_lo", lo, exp_lo);

    // Abort a divide in its tenth busy cycle.
    start = 1'b1; ctrl = MDU_DIV; srcA = 32'd1000; srcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_on", {31'b0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("post_abort_busy", {31'b0, busy}, 32'd0);
    end
    check("post_abort_hi", hi, 32'd0);
    check("post_abort_lo", lo, 32'd0);
    run_op(MDU_MULT, 32'd6, 32'hFFFFFFF9);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      run_op(op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
